// File: rtl/out_wrap_pkg.sv
// Shared constants and pointer helper for the FP output wrapper FIFO controller.
// Feature macro OUT_WRAP_DROP_CNT_EN (drop counter) is consumed by out_wrapper_fifo_ctrl.
package out_wrap_pkg;

   localparam int OW_DEPTH_MIN  = 2;
   localparam int OW_DEPTH_MAX  = 16;
   localparam int OW_DROP_CNT_W = 8;

   // Depth need not be a power of two, so wrap explicitly instead of masking.
   function automatic int ptrNext(input int p, input int depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/out_wrap_ptr.sv
// Read/write pointers and occupancy counter of the output wrapper circular buffer.
// Callers guarantee push only when not full and pop only when not empty.
module out_wrap_ptr
   import out_wrap_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   output logic [PW-1:0] wptr,
   output logic [PW-1:0] rptr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= PW'(ptrNext(int'(wptr), DEPTH));
         if (pop)
            rptr <= PW'(ptrNext(int'(rptr), DEPTH));
         if (push && !pop)
            count <= count + CW'(1);
         else if (!push && pop)
            count <= count - CW'(1);
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/out_wrapper_fifo_ctrl.sv
// DEPTH-entry result FIFO between the FP core and its consumer, with full back-pressure.
// Define OUT_WRAP_DROP_CNT_EN to add the saturating drop_count output.
module out_wrapper_fifo_ctrl
   import out_wrap_pkg::*;
#(
   parameter  int W     = 32,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          done_fp,
   input  logic [W-1:0]  result_in,
   input  logic          result_accept,
   output logic          result_ready,
   output logic [W-1:0]  result_out,
   output logic          full,
   output logic [CW-1:0] count,
   output logic          overflow
`ifdef OUT_WRAP_DROP_CNT_EN
   ,
   output logic [OW_DROP_CNT_W-1:0] drop_count
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < OW_DEPTH_MIN || DEPTH > OW_DEPTH_MAX) begin : gBadDepth
      $error("out_wrapper_fifo_ctrl: DEPTH out of range");
   end

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          empty;
   logic          push;
   logic          pop;

   // Full is judged on the current cycle, so a slot freed by a same-cycle pop is not reused.
   assign push = done_fp & ~full;
   assign pop  = result_ready & result_accept;

   out_wrap_ptr #(.DEPTH(DEPTH)) uPtr (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wptr  (wptr),
      .rptr  (rptr),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Storage is data only and deliberately survives reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= result_in;
   end

   assign result_ready = ~empty;
   assign result_out   = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (done_fp && full)
         overflow <= 1'b1;
   end

`ifdef OUT_WRAP_DROP_CNT_EN
   function automatic logic [OW_DROP_CNT_W-1:0] satInc(input logic [OW_DROP_CNT_W-1:0] c);
      return (&c) ? c : c + OW_DROP_CNT_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_count <= '0;
      else if (done_fp && full)
         drop_count <= satInc(drop_count);
   end
`endif

endmodule

// File: tb/tb_out_wrapper_fifo_ctrl.sv
// Self-checking bench for out_wrapper_fifo_ctrl: vector table, corner sequences, random vs queue model.
// Exercises drop_count when OUT_WRAP_DROP_CNT_EN is defined.
module tb_out_wrapper_fifo_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        done4, acc4, rdy4, full4, ovf4;
   logic [31:0] in4, out4;
   logic [2:0]  cnt4;
   logic        done3, acc3, rdy3, full3, ovf3;
   logic [31:0] in3, out3;
   logic [1:0]  cnt3;
`ifdef OUT_WRAP_DROP_CNT_EN
   logic [7:0]  drop4, drop3;
`endif

   out_wrapper_fifo_ctrl #(.W(32), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .done_fp(done4), .result_in(in4), .result_accept(acc4),
      .result_ready(rdy4), .result_out(out4), .full(full4), .count(cnt4), .overflow(ovf4)
`ifdef OUT_WRAP_DROP_CNT_EN
      , .drop_count(drop4)
`endif
   );

   out_wrapper_fifo_ctrl #(.W(32), .DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .done_fp(done3), .result_in(in3), .result_accept(acc3),
      .result_ready(rdy3), .result_out(out3), .full(full3), .count(cnt3), .overflow(ovf3)
`ifdef OUT_WRAP_DROP_CNT_EN
      , .drop_count(drop3)
`endif
   );

   typedef struct {
      logic        done;
      logic [31:0] data;
      logic        acc;
      logic        rdy;
      logic [31:0] out;
      logic [2:0]  cnt;
      logic        full;
      logic        ovf;
   } vec_t;

   vec_t        vec[$];
   logic [31:0] q[$];
   logic        mOvf;
   int          nChk = 0;
   int          nFail = 0;

   function automatic vec_t mk(logic d, logic [31:0] dat, logic a, logic r,
                               logic [31:0] o, logic [2:0] c, logic f, logic v);
      vec_t t;
      t.done = d; t.data = dat; t.acc = a; t.rdy = r;
      t.out = o; t.cnt = c; t.full = f; t.ovf = v;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk4(input string tag, input logic r, input logic [31:0] o,
                       input logic [2:0] c, input logic f, input logic v);
      chk({tag, ".ready"}, 32'(rdy4), 32'(r));
      chk({tag, ".out"},   out4,      o);
      chk({tag, ".count"}, 32'(cnt4), 32'(c));
      chk({tag, ".full"},  32'(full4), 32'(f));
      chk({tag, ".ovf"},   32'(ovf4), 32'(v));
   endtask

   initial begin
      rst = 1'b1;
      done4 = 1'b0; acc4 = 1'b0; in4 = '0;
      done3 = 1'b0; acc3 = 1'b0; in3 = '0;
      tick();
      tick();
      chk4("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // single result, hold, accept
      vec.push_back(mk(1, 32'h3F800000, 0, 1, 32'h3F800000, 1, 0, 0));
      for (int i = 0; i < 5; i++)
         vec.push_back(mk(0, 32'h0, 0, 1, 32'h3F800000, 1, 0, 0));
      vec.push_back(mk(0, 32'h0, 1, 0, 32'h0, 0, 0, 0));
      // five back-to-back pushes into DEPTH=4, fifth dropped
      vec.push_back(mk(1, 32'd1, 0, 1, 32'd1, 1, 0, 0));
      vec.push_back(mk(1, 32'd2, 0, 1, 32'd1, 2, 0, 0));
      vec.push_back(mk(1, 32'd3, 0, 1, 32'd1, 3, 0, 0));
      vec.push_back(mk(1, 32'd4, 0, 1, 32'd1, 4, 1, 0));
      vec.push_back(mk(1, 32'd5, 0, 1, 32'd1, 4, 1, 1));
      vec.push_back(mk(0, 32'h0, 1, 1, 32'd2, 3, 0, 1));
      vec.push_back(mk(0, 32'h0, 1, 1, 32'd3, 2, 0, 1));
      vec.push_back(mk(0, 32'h0, 1, 1, 32'd4, 1, 0, 1));
      vec.push_back(mk(0, 32'h0, 1, 0, 32'h0, 0, 0, 1));
      // accept while empty is ignored
      vec.push_back(mk(0, 32'h0, 1, 0, 32'h0, 0, 0, 1));
      // simultaneous push and pop at count 2
      vec.push_back(mk(1, 32'hA, 0, 1, 32'hA, 1, 0, 1));
      vec.push_back(mk(1, 32'hB, 0, 1, 32'hA, 2, 0, 1));
      vec.push_back(mk(1, 32'hC, 1, 1, 32'hB, 2, 0, 1));
      vec.push_back(mk(0, 32'h0, 1, 1, 32'hC, 1, 0, 1));
      vec.push_back(mk(0, 32'h0, 1, 0, 32'h0, 0, 0, 1));

      for (int i = 0; i < vec.size(); i++) begin
         done4 = vec[i].done; in4 = vec[i].data; acc4 = vec[i].acc;
         tick();
         chk4($sformatf("vec%0d", i), vec[i].rdy, vec[i].out, vec[i].cnt, vec[i].full, vec[i].ovf);
      end
      done4 = 1'b0; acc4 = 1'b0;

      // asynchronous reset mid-cycle with three entries buffered
      for (int k = 0; k < 3; k++) begin
         done4 = 1'b1; in4 = 32'h100 + k;
         tick();
      end
      done4 = 1'b0;
      chk("pre_rst.count", 32'(cnt4), 32'd3);
      #3;
      rst = 1'b1;
      #1;
      chk4("async_rst", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;

      // full plus done_fp plus accept: pop happens, push dropped
      for (int k = 0; k < 4; k++) begin
         done4 = 1'b1; in4 = 32'h11 + k;
         tick();
      end
      chk4("fill4", 1'b1, 32'h11, 3'd4, 1'b1, 1'b0);
      done4 = 1'b1; in4 = 32'h15; acc4 = 1'b1;
      tick();
      chk4("full_pp", 1'b1, 32'h12, 3'd3, 1'b0, 1'b1);
      done4 = 1'b0;
      tick();
      chk("drain1.out", out4, 32'h13);
      tick();
      chk("drain2.out", out4, 32'h14);
      tick();
      chk4("drain3", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
      acc4 = 1'b0;

      // DEPTH=3: fill and overflow, then stream 10 results with accept held
      for (int k = 0; k < 4; k++) begin
         done3 = 1'b1; in3 = 32'h30 + k;
         tick();
      end
      done3 = 1'b0;
      chk("d3fill.count", 32'(cnt3), 32'd3);
      chk("d3fill.full", 32'(full3), 32'd1);
      chk("d3fill.ovf", 32'(ovf3), 32'd1);
      acc3 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d3drain%0d.out", k), out3, 32'h30 + k);
         tick();
      end
      chk("d3drain.ready", 32'(rdy3), 32'd0);
      for (int k = 0; k < 10; k++) begin
         done3 = 1'b1; in3 = 32'hC0DE0000 + k;
         tick();
         chk($sformatf("stream%0d.out", k), out3, 32'hC0DE0000 + k);
         chk($sformatf("stream%0d.count", k), 32'(cnt3), 32'd1);
      end
      done3 = 1'b0;
      tick();
      chk("stream_end.count", 32'(cnt3), 32'd0);
      chk("stream_end.ready", 32'(rdy3), 32'd0);
      acc3 = 1'b0;

      // randomized traffic against a queue model
      doReset();
      q.delete();
      mOvf = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic d, a;
         logic [31:0] dat;
         d   = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 2) == 0);
         dat = $urandom;
         done4 = d; acc4 = a; in4 = dat;
         if (d && q.size() == 4) mOvf = 1'b1;
         begin
            bit doPush, doPop;
            doPush = d && (q.size() < 4);
            doPop  = a && (q.size() > 0);
            if (doPop) void'(q.pop_front());
            if (doPush) q.push_back(dat);
         end
         tick();
         chk4($sformatf("rnd%0d", i), q.size() != 0, (q.size() != 0) ? q[0] : 32'h0,
              3'(q.size()), q.size() == 4, mOvf);
      end
      done4 = 1'b0; acc4 = 1'b0;

`ifdef OUT_WRAP_DROP_CNT_EN
      doReset();
      chk("drop.reset", 32'(drop4), 32'd0);
      done4 = 1'b1; in4 = 32'h5A;
      for (int k = 0; k < 4; k++) tick();
      chk("drop.none", 32'(drop4), 32'd0);
      tick();
      chk("drop.one", 32'(drop4), 32'd1);
      for (int k = 1; k < 300; k++) tick();
      chk("drop.sat", 32'(drop4), 32'd255);
      chk("drop.ovf", 32'(ovf4), 32'd1);
      done4 = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end

endmodule
